uart_tx_mmio: RTL and testbench

Memory-mapped 8N1 UART transmitter on the CPU data bus, in parallel with the data RAM. Decodes CPU stores to its address window, buffers bytes in a small FIFO and serialises them LSB-first on `tx`. A status register is readable through a registered read port with the same one-cycle latency as the RAM, so the top level can mux it into the load path.

---
 rtl/uart_tx_mmio_if.sv | 22 ++
 rtl/uart_tx_mmio.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the memory-mapped UART transmitter: store/address
// signals from the CPU, window select and registered read data back.
`timescale 1ns/1ps

interface uart_tx_mmio_if;
    logic [31:0] address;
    logic [31:0] w_data;
    logic        MEM_write;
    logic [2:0]  funct3;
    logic        sel;
    logic [31:0] rd_data;

    modport master (
        output address, w_data, MEM_write, funct3,
        input  sel, rd_data
    );

    modport slave (
        input  address, w_data, MEM_write, funct3,
        output sel, rd_data
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA pushes into a byte FIFO, STATUS is read back
// with RAM-like one-cycle latency. Define UART_TX_PARITY_EN for an even parity bit (8E1).
`timescale 1ns/1ps

// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (low) for CLK_DIV cycles
// DATA   | 8 data bits LSB first, CLK_DIV cycles each
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); pops the next byte at its end for gapless frames
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          tx,
    output logic          irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    data_reg;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          overflow;

    logic          sel_int;
    logic          wr_txdata;
    logic          wr_status;
    logic          rd_status;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          baud_done;
    logic          frame_end;
    logic          idle_next;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign sel_int   = (bus.address[31:3] == BASE_ADDR[31:3]);
    assign bus.sel   = sel_int;
    assign wr_txdata = bus.MEM_write && sel_int && !bus.address[2];
    assign wr_status = bus.MEM_write && sel_int && bus.address[2];
    assign rd_status = sel_int && bus.address[2];

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = wr_txdata && !full;
    assign baud_done = (baud == '0);
    assign frame_end = (state == S_STOP) && baud_done;
    assign pop       = !empty && ((state == S_IDLE) || frame_end);
    // The FSM will sit in IDLE after this edge only if there was nothing to pop.
    assign idle_next = ((state == S_IDLE) || frame_end) && empty;

    assign status_word = {23'd0, 5'(count), overflow, (state != S_IDLE), empty, full};

    // funct3, the upper store bytes and the byte offset do not affect this block.
    assign unused_bits = ^{bus.funct3, bus.w_data[31:8], bus.address[1:0]};

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.w_data[7:0];
        end
    end

    // Overflow uses the full flag from before the edge, so a same-cycle pop does not save the byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (wr_txdata && full) begin
                overflow <= 1'b1;
            end else if (wr_status) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud     <= '0;
            bit_idx  <= '0;
            data_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        data_reg <= fifo_mem[rd_ptr];
                        state    <= S_START;
                        tx       <= 1'b0;
                        baud     <= BAUD_LOAD;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        state   <= S_DATA;
                        tx      <= data_reg[0];
                        bit_idx <= '0;
                        baud    <= BAUD_LOAD;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= ^data_reg;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= data_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                        baud  <= BAUD_LOAD;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            data_reg <= fifo_mem[rd_ptr];
                            state    <= S_START;
                            tx       <= 1'b0;
                            baud     <= BAUD_LOAD;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_status ? status_word : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b1;
        end else begin
            irq <= idle_next && (count_next == '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected frames and STATUS reads,
// independent monitors decode the serial line and the read port and compare.
`timescale 1ns/1ps

module tb_uart_tx_mmio;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam logic [31:0] BASE = 32'h0000_4000;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx;
    logic irq;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rst_edges = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (reset) rst_edges <= rst_edges + 1;

    int n_checks = 0;
    int n_errors = 0;

    frame_t      frame_q[$];
    logic [31:0] rd_q[$];
    logic        rd_req = 1'b0;
    int          frames_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int edge_no);
        while (cyc < edge_no) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_irq(input int bound, input string name);
        int k;
        k = 0;
        while (irq !== 1'b1 && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (irq !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: irq still %b after %0d cycles, required 1", name, irq, bound);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int start);
        frame_t f;
        f.data  = d;
        f.start = start;
        frame_q.push_back(f);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int t_edge);
        @(negedge clk);
        bus.address   = a;
        bus.w_data    = d;
        bus.MEM_write = 1'b1;
        rd_req        = 1'b0;
        t_edge        = cyc + 1;
    endtask

    task automatic bus_read_status(input logic [31:0] exp);
        @(negedge clk);
        bus.address   = BASE + 32'd4;
        bus.MEM_write = 1'b0;
        rd_req        = 1'b1;
        rd_q.push_back(exp);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.address   = 32'd0;
        bus.MEM_write = 1'b0;
        rd_req        = 1'b0;
    endtask

    // Single byte from idle: start latency, irq fall and rise.
    task automatic single_frame(input logic [7:0] d);
        int t0;
        bus_write(BASE, {24'd0, d}, t0);
        push_frame(d, t0 + 1);
        bus_idle();
        check("irq_fall", irq, 1'b0);
        wait_to(t0 + 1);
        check("tx_fall", tx, 1'b0);
        wait_to(t0 + FRAME);
        check("irq_before_end", irq, 1'b0);
        wait_to(t0 + FRAME + 1);
        check("irq_rise", irq, 1'b1);
    endtask

    logic rd_took;
    initial begin
        forever begin
            @(posedge clk);
            rd_took = rd_req;
            #1;
            if (rd_took) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_unexpected: read returned %h with nothing queued", bus.rd_data);
                end else begin
                    check("status_read", bus.rd_data, rd_q.pop_front());
                end
            end
        end
    end

    int         mon_start;
    int         mon_rst0;
    logic       mon_start_lvl;
    logic       mon_stop;
    logic       mon_par;
    logic [7:0] mon_byte;
    frame_t     mon_exp;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx === 1'b0) begin
                mon_start = cyc;
                mon_rst0  = rst_edges;
                wait_cyc(CLK_DIV / 2);
                mon_start_lvl = tx;
                for (int i = 0; i < 8; i++) begin
                    wait_cyc(CLK_DIV);
                    mon_byte[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                wait_cyc(CLK_DIV);
                mon_par = tx;
`else
                mon_par = 1'b0;
`endif
                wait_cyc(CLK_DIV);
                mon_stop = tx;
                wait_cyc(CLK_DIV / 2 - 1);
                if (rst_edges != mon_rst0) begin
                    if (frame_q.size() > 0) mon_exp = frame_q.pop_front();
                end else begin
                    frames_seen++;
                    if (frame_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: byte %h started at cycle %0d, none expected",
                                 mon_byte, mon_start);
                    end else begin
                        mon_exp = frame_q.pop_front();
                        check("frame_data", {24'd0, mon_byte}, {24'd0, mon_exp.data});
                        check("frame_start_cycle", mon_start, mon_exp.start);
                        check("start_bit", mon_start_lvl, 1'b0);
                        check("stop_bit", mon_stop, 1'b1);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", mon_par, ^mon_exp.data);
`endif
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    int   t_b2b;
    int   t_ovf;
    int   t_rst;
    int   t_dummy;
    logic idle_ok;
    initial begin
        bus.address   = 32'd0;
        bus.w_data    = 32'd0;
        bus.MEM_write = 1'b0;
        bus.funct3    = 3'b010;
        reset         = 1'b1;
        wait_cyc(3);
        check("reset_tx", tx, 1'b1);
        check("reset_irq", irq, 1'b1);
        check("reset_rd_data", bus.rd_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read_status(32'h0000_0002);
        bus_idle();

        single_frame(8'hA5);
        single_frame(8'h07);

        // Three stores back to back; STATUS read just after the first pop.
        bus_write(BASE, 32'h01, t_b2b);
        bus_write(BASE, 32'h02, t_dummy);
        bus_write(BASE, 32'h03, t_dummy);
        bus_read_status(32'h0000_0024);
        bus_idle();
        for (int k = 0; k < 3; k++) push_frame(8'(k + 1), t_b2b + 1 + k * FRAME);
        wait_irq(4 * FRAME, "b2b_done");

        // One frame in flight, then nine more stores: the ninth is dropped.
        bus_write(BASE, 32'h10, t_ovf);
        push_frame(8'h10, t_ovf + 1);
        bus_idle();
        bus_idle();
        for (int i = 1; i <= 9; i++) bus_write(BASE, 32'h10 + 32'(i), t_dummy);
        for (int i = 1; i <= 8; i++) push_frame(8'(8'h10 + i), t_ovf + 1 + i * FRAME);
        bus_read_status(32'h0000_008D);
        bus_write(BASE + 32'd4, 32'h0, t_dummy);
        bus_read_status(32'h0000_0085);
        bus_idle();
        wait_irq(10 * FRAME + 20, "ovf_done");
        bus_read_status(32'h0000_0002);
        bus_idle();

        // Reset in the middle of the data bits of a 0x00 frame, with 0x55 queued behind it.
        bus_write(BASE, 32'h00, t_rst);
        push_frame(8'h00, t_rst + 1);
        bus_write(BASE, 32'h55, t_dummy);
        bus_idle();
        wait_to(t_rst + 9);
        check("data_bit_low", tx, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        wait_to(t_rst + 10);
        check("reset_mid_tx", tx, 1'b1);
        check("reset_mid_irq", irq, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        bus_read_status(32'h0000_0002);
        bus_idle();
        idle_ok = 1'b1;
        repeat (3 * FRAME) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) idle_ok = 1'b0;
        end
        check("no_frames_after_reset", idle_ok, 1'b1);

        check("frames_seen", frames_seen, 32'd14);
        check("frame_queue_drained", frame_q.size(), 32'd0);
        check("read_queue_drained", rd_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
